cfa_diag_window: RTL and testbench
==================================

Name: cfa_diag_window

Overview:
- Streaming neighbourhood generator that feeds the diagonal colour-difference stage of the CFA demosaic pipeline (the block computing (ΣG_diag − ΣRB_diag)/4).
- Accepts two co-registered raster pixel streams: a green plane (G) and a raw red/blue plane (RB).
- Uses line buffers and column delays to present, for each interior centre pixel, the four diagonal neighbours of each plane on registered outputs.
- Port names of the diagonal outputs match the consumer's inputs, so the two blocks connect one-to-one.

Parameters:
- DATA_W, 12, pixel width for both planes.
- IMG_W, 640, active pixels per line (≥3).
- IMG_H, 480, active lines per frame (≥3).
- COL_W, 10, column counter width (≥ clog2(IMG_W)).
- ROW_W, 9, row counter width (≥ clog2(IMG_H)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel qualifier; one pixel per cycle when high; no back-pressure.
- in_sof  in  1  start of frame; marks pixel (0,0); sampled only with in_valid.
- in_g  in  DATA_W  green plane pixel.
- in_rb  in  DATA_W  raw R/B plane pixel.
- out_valid  in→out  1  output window valid (registered).
- G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1  out  DATA_W each  G at centre offsets (row,col) = (−1,−1), (−1,+1), (+1,−1), (+1,+1).
- RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1  out  DATA_W each  RB at the same offsets.
- out_row  out  ROW_W  centre row of current window.
- out_col  out  COL_W  centre column of current window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset is asynchronous and active-high.
  - All outputs reset to 0, counters reset to 0, FSM resets to IDLE.
  - Line-buffer contents are not cleared; out_valid gating ensures stale data is never presented.
- FSM states:
  - IDLE: discard input until in_valid && in_sof, then go to ACTIVE; that pixel is (0,0).
  - ACTIVE: accept pixels and advance col; at col = IMG_W−1, wrap col to 0 and increment row.
  - ACTIVE → DONE on acceptance of pixel (IMG_H−1, IMG_W−1); frame_done pulses on the following cycle.
  - DONE: ignore input until in_valid && in_sof, which restarts at (0,0). Go directly to ACTIVE; do not pass through IDLE.
  - in_sof accepted while ACTIVE: abandon the partial frame, treat that pixel as (0,0). out_valid must not assert until two new full lines plus two pixels have arrived.
  - in_sof with in_valid low is ignored.
- Storage, per plane:
  - A 2-line delay (depth 2×IMG_W, or two IMG_W buffers) supplies row r−2.
  - A 2-stage column delay on the current row and on the row r−2 tap.
- On acceptance of pixel (r,c) with r≥2 and c≥2, the centre is (r−1,c−1):
  - *_m1_m1 = pixel(r−2,c−2)
  - *_m1_p1 = pixel(r−2,c)
  - *_p1_m1 = pixel(r,c−2)
  - *_p1_p1 = pixel(r,c)
- Latency: 1 clock from accepting pixel (r,c) to out_valid=1 with out_row=r−1, out_col=c−1.
- out_valid is low for border centres (row 0, row IMG_H−1, col 0, col IMG_W−1). Windows never span a line wrap.
- When out_valid=0, data outputs hold their last values.
- in_valid gaps: all state holds and out_valid=0 during the gap. Window contents are unaffected by gaps.
- Valid windows per frame: (IMG_H−2)×(IMG_W−2).
- No arithmetic is performed; data passes through bit-exact.

Test Plan:
- IMG_W=4, IMG_H=4, in_g=16r+c, in_rb=200+16r+c, continuous valid, sof on (0,0) → first out_valid the cycle after (2,2): G_m1_m1=0, G_m1_p1=2, G_p1_m1=32, G_p1_p1=34, RB=200,202,232,234, out_row=1, out_col=1. Next window: G=1,3,33,35, out_col=2. Exactly 4 valid windows; frame_done pulses after (3,3).
- Same frame with in_valid deasserted for 3 cycles after every pixel → identical window sequence and values; out_valid never high during gaps.
- Assert rst mid-frame at pixel (2,1), then a new sof frame → out_valid=0 immediately, all outputs 0. The first valid window of the new frame contains only new-frame data (G=0,2,32,34).
- in_sof at pixel (2,3) of a running frame → counters restart, no out_valid until new (2,2); windows match the clean-frame values.
- Stream pixels in IDLE and in DONE without sof → ignored, no out_valid. A second sof frame after DONE → correct windows.
- Chain to the colour-difference stage with a random 12-bit file-driven frame → the stage output equals (ΣG_diag − ΣRB_diag)/4, computed in the bench, for every valid window.

Source files
------------

// File: rtl/cfa_diag_window_if.sv
// Pixel-in / diagonal-window-out bundle for cfa_diag_window.
// Output names match the colour-difference stage inputs, so the two blocks connect one-to-one.
interface cfa_diag_window_if #(
    parameter int DATA_W = 12,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 9
);
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_g;
    logic [DATA_W-1:0] in_rb;

    logic              out_valid;
    logic [DATA_W-1:0] G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1;
    logic [DATA_W-1:0] RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              frame_done;

    modport master (
        output in_valid, in_sof, in_g, in_rb,
        input  out_valid, G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
               RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1, out_row, out_col, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_g, in_rb,
        output out_valid, G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
               RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1, out_row, out_col, frame_done
    );
endinterface

// File: rtl/cfa_diag_window.sv
// Streaming 3x3 diagonal-neighbour generator for the G and raw R/B planes.
// Presents the four diagonal taps of each plane one clock after the bottom-right pixel arrives.
module cfa_diag_window #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 9
) (
    input  logic             clk,
    input  logic             rst,
    cfa_diag_window_if.slave bus
);
    localparam int NP = 2;  // plane 0 = G, plane 1 = RB
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t           r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_out_valid;
    logic             r_frame_done;
    logic [ROW_W-1:0] r_out_row;
    logic [COL_W-1:0] r_out_col;

    logic             w_start, w_acc, w_eol, w_eof, w_win;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [AW-1:0]    w_addr;

    logic [NP-1:0][DATA_W-1:0] w_pix, w_tap;
    logic [NP-1:0][DATA_W-1:0] r_cur_d1, r_cur_d2, r_tap_d1, r_tap_d2;
    logic [NP-1:0][DATA_W-1:0] r_mm, r_mp, r_pm, r_pp;

    // An sof pixel is (0,0) in any state, which also abandons a partial frame.
    assign w_start = bus.in_valid & bus.in_sof;
    assign w_acc   = w_start | (bus.in_valid & (r_state == ACTIVE));
    assign w_col   = w_start ? '0 : r_col;
    assign w_row   = w_start ? '0 : r_row;
    assign w_addr  = w_col[AW-1:0];
    assign w_eol   = (w_col == COL_W'(IMG_W - 1));
    assign w_eof   = w_eol && (w_row == ROW_W'(IMG_H - 1));
    assign w_win   = w_acc && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
    assign w_pix   = {bus.in_rb, bus.in_g};

    // Two cascaded single-line buffers per plane: lb1 holds row r-1, lb2 row r-2.
    for (genvar p = 0; p < NP; p++) begin : g_plane
        logic [DATA_W-1:0] r_lb1 [IMG_W];
        logic [DATA_W-1:0] r_lb2 [IMG_W];

        assign w_tap[p] = r_lb2[w_addr];

        always_ff @(posedge clk) begin
            if (w_acc) begin
                r_lb2[w_addr] <= r_lb1[w_addr];
                r_lb1[w_addr] <= w_pix[p];
            end
        end
    end

    // Column delays shift only on accepted pixels, so input gaps never disturb the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_d1 <= '0;
            r_cur_d2 <= '0;
            r_tap_d1 <= '0;
            r_tap_d2 <= '0;
            r_mm     <= '0;
            r_mp     <= '0;
            r_pm     <= '0;
            r_pp     <= '0;
        end else if (w_acc) begin
            r_cur_d1 <= w_pix;
            r_cur_d2 <= r_cur_d1;
            r_tap_d1 <= w_tap;
            r_tap_d2 <= r_tap_d1;
            if (w_win) begin
                r_mm <= r_tap_d2;
                r_mp <= w_tap;
                r_pm <= r_cur_d2;
                r_pp <= w_pix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
        end else begin
            r_out_valid  <= w_win;
            r_frame_done <= w_acc && w_eof;
            if (w_acc) begin
                r_col   <= w_eol ? '0 : w_col + 1'b1;
                r_row   <= w_eol ? w_row + 1'b1 : w_row;
                r_state <= w_eof ? DONE : ACTIVE;
                if (w_win) begin
                    r_out_row <= w_row - 1'b1;
                    r_out_col <= w_col - 1'b1;
                end
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.out_row    = r_out_row;
    assign bus.out_col    = r_out_col;
    assign bus.G_m1_m1    = r_mm[0];
    assign bus.G_m1_p1    = r_mp[0];
    assign bus.G_p1_m1    = r_pm[0];
    assign bus.G_p1_p1    = r_pp[0];
    assign bus.RB_m1_m1   = r_mm[1];
    assign bus.RB_m1_p1   = r_mp[1];
    assign bus.RB_p1_m1   = r_pm[1];
    assign bus.RB_p1_p1   = r_pp[1];
endmodule

// File: tb/tb_cfa_diag_window.sv
// Directed bench for cfa_diag_window on a 4x4 frame: clean, gapped, reset, sof-restart,
// idle/done filtering and a random frame checked through a colour-difference model.
module tb_cfa_diag_window;
    localparam int DW = 12, W = 4, H = 4, CW = 10, RW = 9;
    localparam int OW = 8 * DW + RW + CW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cfa_diag_window_if #(.DATA_W(DW), .COL_W(CW), .ROW_W(RW)) bus();

    cfa_diag_window #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .COL_W(CW), .ROW_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] fg  [H][W];
    logic [DW-1:0] frb [H][W];
    logic [OW-1:0] obs;

    assign obs = {bus.G_m1_m1, bus.G_m1_p1, bus.G_p1_m1, bus.G_p1_p1,
                  bus.RB_m1_m1, bus.RB_m1_p1, bus.RB_p1_m1, bus.RB_p1_p1,
                  bus.out_row, bus.out_col};

    // Expected window after accepting pixel (r,c), r>=2 and c>=2.
    function automatic logic [OW-1:0] model(int r, int c);
        return {fg[r-2][c-2], fg[r-2][c], fg[r][c-2], fg[r][c],
                frb[r-2][c-2], frb[r-2][c], frb[r][c-2], frb[r][c],
                RW'(r - 1), CW'(c - 1)};
    endfunction

    // mode 0: ramp, 1: distinct junk, 2: random
    task automatic load_frame(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0: begin fg[r][c] = DW'(16*r + c);         frb[r][c] = DW'(200 + 16*r + c); end
                    1: begin fg[r][c] = DW'(12'h800 + 16*r + c); frb[r][c] = DW'(12'h900 + 16*r + c); end
                    default: begin fg[r][c] = DW'($urandom); frb[r][c] = DW'($urandom); end
                endcase
            end
    endtask

    task automatic push(input logic v, input logic s, input logic [DW-1:0] g, input logic [DW-1:0] rb);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_g     = g;
        bus.in_rb    = rb;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.frame_done); end
        n_vec++; if (obs !== '0) begin n_err++; $display("FAIL reset_outputs got %h want 0", obs); end
    endtask

    task automatic test_clean_frame();
        int nwin = 0;
        load_frame(0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                push(1'b1, (r == 0 && c == 0), fg[r][c], frb[r][c]);
                n_vec++;
                if (bus.out_valid !== (r >= 2 && c >= 2)) begin
                    n_err++; $display("FAIL clean_valid (%0d,%0d) got %b", r, c, bus.out_valid);
                end else if (bus.out_valid && obs !== model(r, c)) begin
                    n_err++; $display("FAIL clean_window (%0d,%0d) got %h want %h", r, c, obs, model(r, c));
                end
                if (bus.out_valid) nwin++;
                n_vec++;
                if (bus.frame_done !== (r == H-1 && c == W-1)) begin
                    n_err++; $display("FAIL clean_done (%0d,%0d) got %b", r, c, bus.frame_done);
                end
            end
        n_vec++; if (nwin != 4) begin n_err++; $display("FAIL clean_count got %0d want 4", nwin); end
    endtask

    task automatic test_gaps();
        load_frame(0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                push(1'b1, (r == 0 && c == 0), fg[r][c], frb[r][c]);
                n_vec++;
                if (bus.out_valid !== (r >= 2 && c >= 2)) begin
                    n_err++; $display("FAIL gap_valid (%0d,%0d) got %b", r, c, bus.out_valid);
                end else if (bus.out_valid && obs !== model(r, c)) begin
                    n_err++; $display("FAIL gap_window (%0d,%0d) got %h want %h", r, c, obs, model(r, c));
                end
                for (int g = 0; g < 3; g++) begin
                    push(1'b0, 1'b0, 12'hfff, 12'hfff);
                    n_vec++;
                    if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
                        n_err++; $display("FAIL gap_idle (%0d,%0d) valid %b done %b want 0", r, c, bus.out_valid, bus.frame_done);
                    end
                    if (r >= 2 && c >= 2) begin
                        n_vec++;
                        if (obs !== model(r, c)) begin
                            n_err++; $display("FAIL gap_hold (%0d,%0d) got %h want %h", r, c, obs, model(r, c));
                        end
                    end
                end
            end
    endtask

    task automatic test_rst_midframe();
        load_frame(1);
        for (int i = 0; i <= 2*W + 1; i++)  // pixels (0,0)..(2,1)
            push(1'b1, (i == 0), fg[i / W][i % W], frb[i / W][i % W]);
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0 || obs !== '0) begin
            n_err++; $display("FAIL rst_async valid %b done %b outs %h want all 0", bus.out_valid, bus.frame_done, obs);
        end
        @(posedge clk); #1 rst = 1'b0;
        load_frame(0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                push(1'b1, (r == 0 && c == 0), fg[r][c], frb[r][c]);
                n_vec++;
                if (bus.out_valid !== (r >= 2 && c >= 2)) begin
                    n_err++; $display("FAIL rst_valid (%0d,%0d) got %b", r, c, bus.out_valid);
                end else if (bus.out_valid && obs !== model(r, c)) begin
                    n_err++; $display("FAIL rst_window (%0d,%0d) got %h want %h", r, c, obs, model(r, c));
                end
            end
    endtask

    task automatic test_sof_restart();
        load_frame(1);
        for (int i = 0; i <= 2*W + 2; i++)  // pixels (0,0)..(2,2); sof lands on the (2,3) slot
            push(1'b1, (i == 0), fg[i / W][i % W], frb[i / W][i % W]);
        load_frame(0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                push(1'b1, (r == 0 && c == 0), fg[r][c], frb[r][c]);
                n_vec++;
                if (bus.out_valid !== (r >= 2 && c >= 2)) begin
                    n_err++; $display("FAIL sof_valid (%0d,%0d) got %b", r, c, bus.out_valid);
                end else if (bus.out_valid && obs !== model(r, c)) begin
                    n_err++; $display("FAIL sof_window (%0d,%0d) got %h want %h", r, c, obs, model(r, c));
                end
                n_vec++;
                if (bus.frame_done !== (r == H-1 && c == W-1)) begin
                    n_err++; $display("FAIL sof_done (%0d,%0d) got %b", r, c, bus.frame_done);
                end
            end
    endtask

    task automatic test_idle_done();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push(1'b0, 1'b1, 12'h111, 12'h222);  // sof without valid must not start a frame
        for (int i = 0; i < 12; i++) begin
            push(1'b1, 1'b0, DW'(i), DW'(i));
            n_vec++;
            if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL idle_ignore i%0d got %b want 0", i, bus.out_valid); end
        end
        load_frame(0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                push(1'b1, (r == 0 && c == 0), fg[r][c], frb[r][c]);
                n_vec++;
                if (bus.out_valid !== (r >= 2 && c >= 2)) begin
                    n_err++; $display("FAIL idle_frame_valid (%0d,%0d) got %b", r, c, bus.out_valid);
                end else if (bus.out_valid && obs !== model(r, c)) begin
                    n_err++; $display("FAIL idle_frame_window (%0d,%0d) got %h want %h", r, c, obs, model(r, c));
                end
            end
        for (int i = 0; i < 12; i++) begin
            push(1'b1, 1'b0, DW'(i), DW'(i));
            n_vec++;
            if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
                n_err++; $display("FAIL done_ignore i%0d valid %b done %b want 0", i, bus.out_valid, bus.frame_done);
            end
        end
    endtask

    // Random frame straight out of DONE, also checked through the colour-difference formula.
    task automatic test_random_frame();
        int sg, srb, eg, erb;
        load_frame(2);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                push(1'b1, (r == 0 && c == 0), fg[r][c], frb[r][c]);
                n_vec++;
                if (bus.out_valid !== (r >= 2 && c >= 2)) begin
                    n_err++; $display("FAIL rand_valid (%0d,%0d) got %b", r, c, bus.out_valid);
                end else if (bus.out_valid) begin
                    if (obs !== model(r, c)) begin
                        n_err++; $display("FAIL rand_window (%0d,%0d) got %h want %h", r, c, obs, model(r, c));
                    end
                    sg  = int'(bus.G_m1_m1) + int'(bus.G_m1_p1) + int'(bus.G_p1_m1) + int'(bus.G_p1_p1);
                    srb = int'(bus.RB_m1_m1) + int'(bus.RB_m1_p1) + int'(bus.RB_p1_m1) + int'(bus.RB_p1_p1);
                    eg  = int'(fg[r-2][c-2]) + int'(fg[r-2][c]) + int'(fg[r][c-2]) + int'(fg[r][c]);
                    erb = int'(frb[r-2][c-2]) + int'(frb[r-2][c]) + int'(frb[r][c-2]) + int'(frb[r][c]);
                    n_vec++;
                    if ((sg - srb) / 4 != (eg - erb) / 4) begin
                        n_err++; $display("FAIL rand_cdiff (%0d,%0d) got %0d want %0d", r, c, (sg - srb) / 4, (eg - erb) / 4);
                    end
                end
            end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_g     = '0;
        bus.in_rb    = '0;
        test_reset();
        test_clean_frame();
        test_gaps();
        test_rst_midframe();
        test_sof_restart();
        test_idle_done();
        test_random_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
